// File: rtl/mdu_sequencer_if.sv
// Request/result bundle between the issuing pipeline and the multiply/divide
// sequencer.
//   master: drives start, op, rs_val, rt_val; observes busy, done, hi, lo, div_zero
//   slave : the sequencer side of the same signals
interface mdu_sequencer_if;
    localparam int unsigned DATA_W = 32;

    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              div_zero;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative MULTU/DIVU controller that borrows the shared 32-bit ALU for one
// add (multiply) or subtract (restoring divide) per cycle over 32 cycles.
// Optional signed MULT/DIV support is compiled in with `define MDU_SIGNED_EN.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   mdu (slave)       start/op/rs_val/rt_val request; busy/done/hi/lo/div_zero result
//   alu_a, alu_b      ALU operands (combinational, valid while busy)
//   alu_gin           ALU control: 010 add, 110 sub
//   alu_sum           ALU result fed back in the same cycle
//   alu_zout          ALU zero flag, reserved
module mdu_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned ITER  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mdu_sequencer_if.slave   mdu,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_gin,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_zout
);
    localparam int unsigned      CNT_W   = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(ITER - 1);
    localparam logic [2:0]       GIN_ADD = 3'b010;
    localparam logic [2:0]       GIN_SUB = 3'b110;

`ifdef MDU_SIGNED_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2, S_FIX = 2'd3} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] opd_q, opd_d;       // multiplicand or divisor
    logic             is_div_q, is_div_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] mul_b;
    logic [WIDTH-1:0] div_s;
    logic             carry;
    logic             borrow;
    logic             sgn_req;
    logic             rs_neg, rt_neg;
    logic [WIDTH-1:0] rs_abs, rt_abs;

`ifdef MDU_SIGNED_EN
    logic             fix_q, fix_d;       // signed op awaiting sign correction
    logic             neg_q, neg_d;       // operand signs differ
    logic             rs_sgn_q, rs_sgn_d; // dividend was negative
    logic [2*WIDTH-1:0] prod_neg;
    logic             unused_ok;
    assign unused_ok = alu_zout;
`else
    logic             unused_ok;
    assign unused_ok = ^{alu_zout, mdu.op[1]};
`endif

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            count_q  <= '0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MDU_SIGNED_EN
            fix_q    <= 1'b0;
            neg_q    <= 1'b0;
            rs_sgn_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            count_q  <= count_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MDU_SIGNED_EN
            fix_q    <= fix_d;
            neg_q    <= neg_d;
            rs_sgn_q <= rs_sgn_d;
`endif
        end
    end

    // Next-state, iteration datapath and ALU drive
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        count_d  = count_q;
        dz_d     = dz_q;
        alu_a    = '0;
        alu_b    = '0;
        alu_gin  = GIN_ADD;
`ifdef MDU_SIGNED_EN
        fix_d    = fix_q;
        neg_d    = neg_q;
        rs_sgn_d = rs_sgn_q;
        sgn_req  = mdu.op[1];
        prod_neg = -{hi_q, lo_q};
`else
        sgn_req  = 1'b0;
`endif
        rs_neg   = sgn_req & mdu.rs_val[WIDTH-1];
        rt_neg   = sgn_req & mdu.rt_val[WIDTH-1];
        rs_abs   = rs_neg ? -mdu.rs_val : mdu.rs_val;
        rt_abs   = rt_neg ? -mdu.rt_val : mdu.rt_val;

        mul_b    = lo_q[0] ? opd_q : '0;
        div_s    = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        // Carry/borrow recovered from operand and result MSBs only
        carry    = (hi_q[WIDTH-1] & mul_b[WIDTH-1]) |
                   ((hi_q[WIDTH-1] | mul_b[WIDTH-1]) & ~alu_sum[WIDTH-1]);
        borrow   = (~div_s[WIDTH-1] & opd_q[WIDTH-1]) |
                   ((~div_s[WIDTH-1] | opd_q[WIDTH-1]) & alu_sum[WIDTH-1]);

        case (state_q)
            S_IDLE: begin
                if (mdu.start) begin
                    is_div_d = mdu.op[0];
                    opd_d    = mdu.op[0] ? rt_abs : rs_abs;
                    hi_d     = '0;
                    lo_d     = mdu.op[0] ? rs_abs : rt_abs;
                    count_d  = '0;
                    dz_d     = 1'b0;
                    state_d  = S_RUN;
`ifdef MDU_SIGNED_EN
                    fix_d    = sgn_req;
                    neg_d    = rs_neg ^ rt_neg;
                    rs_sgn_d = rs_neg;
`endif
                    if (mdu.op[0] && (mdu.rt_val == '0)) begin
                        hi_d    = mdu.rs_val;
                        lo_d    = '1;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    alu_a   = div_s;
                    alu_b   = opd_q;
                    alu_gin = GIN_SUB;
                    // hi_q[31] set means the shifted remainder overflows 32 bits
                    if (hi_q[WIDTH-1] | ~borrow) begin
                        hi_d = alu_sum;
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = div_s;
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    alu_a = hi_q;
                    alu_b = mul_b;
                    hi_d  = {carry, alu_sum[WIDTH-1:1]};
                    lo_d  = {alu_sum[0], lo_q[WIDTH-1:1]};
                end
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST) begin
`ifdef MDU_SIGNED_EN
                    state_d = fix_q ? S_FIX : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef MDU_SIGNED_EN
            S_FIX: begin
                if (is_div_q) begin
                    if (neg_q)    lo_d = -lo_q;
                    if (rs_sgn_q) hi_d = -hi_q;
                end else if (neg_q) begin
                    {hi_d, lo_d} = prod_neg;
                end
                state_d = S_DONE;
            end
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        // done trails the DONE state by one cycle
        done_d = (state_q == S_DONE);
    end

    assign mdu.busy     = busy_q;
    assign mdu.done     = done_q;
    assign mdu.hi       = hi_q;
    assign mdu.lo       = lo_q;
    assign mdu.div_zero = dz_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer with a behavioural ALU attached.
module tb_mdu_sequencer;
    logic        clk;
    logic        rst_n;
    logic [31:0] alu_a, alu_b, alu_sum;
    logic [2:0]  alu_gin;
    logic        alu_zout;

    mdu_sequencer_if mif ();

    mdu_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mdu      (mif),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_gin  (alu_gin),
        .alu_sum  (alu_sum),
        .alu_zout (alu_zout)
    );

    // Shared ALU: add or subtract only
    assign alu_sum  = (alu_gin == 3'b110) ? (alu_a - alu_b) : (alu_a + alu_b);
    assign alu_zout = (alu_sum == 32'd0);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    int r_lat, r_busy, r_gin_bad, r_dones;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and watch 40 cycles; optional extra start at cycle inj,
    // optional async reset at cycle rst_at (-1 disables either).
    task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [2:0] gin_exp, input int inj, input int rst_at);
        @(negedge clk);
        mif.start  = 1'b1;
        mif.op     = op;
        mif.rs_val = rs;
        mif.rt_val = rt;
        @(posedge clk);
        #1;
        r_lat = -1; r_busy = 0; r_gin_bad = 0; r_dones = 0;
        for (int m = 0; m < 40; m++) begin
            if (mif.busy) begin
                r_busy++;
                if (alu_gin !== gin_exp) r_gin_bad++;
            end
            if (mif.done) begin
                r_dones++;
                if (r_lat < 0) r_lat = m;
            end
            if (m == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_mid_busy", 64'(mif.busy), 64'd0);
                check_eq("rst_mid_hi",   64'(mif.hi),   64'd0);
                check_eq("rst_mid_lo",   64'(mif.lo),   64'd0);
                #1;
                rst_n = 1'b1;
            end
            @(negedge clk);
            mif.start = 1'b0;
            if (m == inj) begin
                mif.start  = 1'b1;
                mif.op     = 2'b00;
                mif.rs_val = 32'd3;
                mif.rt_val = 32'd5;
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        mif.start  = 1'b0;
        mif.op     = 2'b00;
        mif.rs_val = 32'd0;
        mif.rt_val = 32'd0;
        #2;
        check_eq("rst_hi",       64'(mif.hi),       64'd0);
        check_eq("rst_lo",       64'(mif.lo),       64'd0);
        check_eq("rst_busy",     64'(mif.busy),     64'd0);
        check_eq("rst_done",     64'(mif.done),     64'd0);
        check_eq("rst_div_zero", 64'(mif.div_zero), 64'd0);
        check_eq("rst_alu_a",    64'(alu_a),        64'd0);
        check_eq("rst_alu_b",    64'(alu_b),        64'd0);
        check_eq("rst_alu_gin",  64'(alu_gin),      64'd2);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // MULTU max*max
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, -1, -1);
        check_eq("multu_max_lat",   64'(r_lat),     64'd33);
        check_eq("multu_max_busy",  64'(r_busy),    64'd32);
        check_eq("multu_max_dones", 64'(r_dones),   64'd1);
        check_eq("multu_max_gin",   64'(r_gin_bad), 64'd0);
        check_eq("multu_max_hi",    64'(mif.hi),    64'hFFFF_FFFE);
        check_eq("multu_max_lo",    64'(mif.lo),    64'h0000_0001);
        check_eq("idle_alu_gin",    64'(alu_gin),   64'd2);
        check_eq("idle_alu_a",      64'(alu_a),     64'd0);

        // DIVU by zero
        run_op(2'b01, 32'h1234_5678, 32'd0, 3'b110, -1, -1);
        check_eq("div0_lat",   64'(r_lat),        64'd1);
        check_eq("div0_busy",  64'(r_busy),       64'd0);
        check_eq("div0_dones", 64'(r_dones),      64'd1);
        check_eq("div0_hi",    64'(mif.hi),       64'h1234_5678);
        check_eq("div0_lo",    64'(mif.lo),       64'hFFFF_FFFF);
        check_eq("div0_dz",    64'(mif.div_zero), 64'd1);

        // DIVU 100/7
        run_op(2'b01, 32'd100, 32'd7, 3'b110, -1, -1);
        check_eq("divu_lat",  64'(r_lat),        64'd33);
        check_eq("divu_busy", 64'(r_busy),       64'd32);
        check_eq("divu_gin",  64'(r_gin_bad),    64'd0);
        check_eq("divu_lo",   64'(mif.lo),       64'd14);
        check_eq("divu_hi",   64'(mif.hi),       64'd2);
        check_eq("divu_dz",   64'(mif.div_zero), 64'd0);

        // Second start during RUN is ignored
        run_op(2'b01, 32'd100, 32'd7, 3'b110, 5, -1);
        check_eq("ign_dones", 64'(r_dones),   64'd1);
        check_eq("ign_lat",   64'(r_lat),     64'd33);
        check_eq("ign_gin",   64'(r_gin_bad), 64'd0);
        check_eq("ign_lo",    64'(mif.lo),    64'd14);
        check_eq("ign_hi",    64'(mif.hi),    64'd2);

        // Reset mid-operation, then a fresh multiply
        run_op(2'b00, 32'h0001_2345, 32'h0006_789A, 3'b010, -1, 10);
        check_eq("rst_dones", 64'(r_dones), 64'd0);
        run_op(2'b00, 32'd3, 32'd5, 3'b010, -1, -1);
        check_eq("mul35_lat", 64'(r_lat),  64'd33);
        check_eq("mul35_lo",  64'(mif.lo), 64'd15);
        check_eq("mul35_hi",  64'(mif.hi), 64'd0);

`ifdef MDU_SIGNED_EN
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 3'b110, -1, -1);
        check_eq("div_s_lat", 64'(r_lat),  64'd34);
        check_eq("div_s_lo",  64'(mif.lo), 64'hFFFF_FFFD);
        check_eq("div_s_hi",  64'(mif.hi), 64'hFFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFFD, 32'd4, 3'b010, -1, -1);
        check_eq("mul_s_lat", 64'(r_lat),  64'd34);
        check_eq("mul_s_hi",  64'(mif.hi), 64'hFFFF_FFFF);
        check_eq("mul_s_lo",  64'(mif.lo), 64'hFFFF_FFF4);
`else
        // Without signed support op[1] is ignored
        run_op(2'b10, 32'd3, 32'd5, 3'b010, -1, -1);
        check_eq("op10_lat", 64'(r_lat),  64'd33);
        check_eq("op10_lo",  64'(mif.lo), 64'd15);
        run_op(2'b11, 32'd100, 32'd7, 3'b110, -1, -1);
        check_eq("op11_lo",  64'(mif.lo), 64'd14);
        check_eq("op11_hi",  64'(mif.hi), 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
